// File: rtl/fifo_pkg.sv
// Shared defaults and helpers for the read-side FIFO packer.
package fifo_pkg;

    localparam int unsigned DATASIZEL_DEFAULT = 8;
    localparam int unsigned PACK_DEFAULT      = 4;

    // Returns a mask with the low cnt bits set; callers cast it to their lane count.
    function automatic logic [31:0] keep_mask(input int unsigned cnt);
        logic [31:0] m;
        m = '0;
        for (int unsigned i = 0; i < 32; i++) begin
            if (i < cnt) m[i] = 1'b1;
        end
        return m;
    endfunction

endpackage

// File: rtl/fifo_rd_packer.sv
// Pops bytes from a show-ahead FIFO read port and packs PACK of them into
// one little-endian word on a valid/ready stream; flush emits a partial word.
module fifo_rd_packer
    import fifo_pkg::*;
#(
    parameter int unsigned DATASIZEL = DATASIZEL_DEFAULT,
    parameter int unsigned PACK      = PACK_DEFAULT
) (
    input  logic                      rclk,
    input  logic                      rrst,
    input  logic                      rempty,
    input  logic [DATASIZEL-1:0]      rdata,
    output logic                      rinc,
    input  logic                      flush,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [DATASIZEL*PACK-1:0] m_data,
    output logic [PACK-1:0]           m_keep,
    output logic                      m_last
);

    localparam int unsigned OUTW = DATASIZEL * PACK;
    localparam int unsigned NW   = $clog2(PACK + 1);
    localparam logic [NW-1:0] N_FULL = NW'(PACK);
    localparam logic [NW-1:0] N_LAST = NW'(PACK - 1);

    logic [NW-1:0]   n, n_nx;
    logic [OUTW-1:0] acc, acc_nx;
    logic            flush_pend, fp_nx;
    logic            pop, ofree;
    logic            load, ld_last;
    logic [PACK-1:0] ld_keep;
    logic [OUTW-1:0] ld_data;

    assign rinc  = !rrst && !flush_pend && (n < N_FULL);
    assign pop   = rinc && !rempty;
    assign ofree = !m_valid || m_ready;

    // Accumulator update, mode decisions (FILL/HOLD/FLUSH) and output-load selection.
    always_comb begin
        acc_nx  = acc;
        n_nx    = n;
        fp_nx   = flush_pend;
        load    = 1'b0;
        ld_last = 1'b0;
        ld_keep = '1;
        ld_data = '0;

        for (int unsigned i = 0; i < PACK; i++) begin
            if (pop && n == NW'(i)) acc_nx[i*DATASIZEL +: DATASIZEL] = rdata;
        end

        if (flush_pend) begin
            if (n == '0) begin
                fp_nx = 1'b0;
            end else if (ofree) begin
                load    = 1'b1;
                ld_last = 1'b1;
                ld_keep = PACK'(keep_mask(32'(n)));
                n_nx    = '0;
                fp_nx   = 1'b0;
            end
        end else if (n == N_FULL) begin
            if (ofree) begin
                load    = 1'b1;
                ld_last = flush;
                n_nx    = '0;
            end else begin
                fp_nx = flush;
            end
        end else if (pop && n == N_LAST) begin
            // A flush arriving with the completing byte marks this word last
            // directly instead of leaving a pending flush on an empty accumulator.
            if (ofree) begin
                load    = 1'b1;
                ld_last = flush;
                n_nx    = '0;
            end else begin
                n_nx  = N_FULL;
                fp_nx = flush;
            end
        end else begin
            n_nx  = n + NW'(pop);
            fp_nx = flush;
        end

        for (int unsigned i = 0; i < PACK; i++) begin
            if (ld_keep[i]) ld_data[i*DATASIZEL +: DATASIZEL] = acc_nx[i*DATASIZEL +: DATASIZEL];
        end
    end

    // Accumulator, flush-pending flag and output register.
    always_ff @(posedge rclk) begin
        if (rrst) begin
            n          <= '0;
            acc        <= '0;
            flush_pend <= 1'b0;
            m_valid    <= 1'b0;
            m_data     <= '0;
            m_keep     <= '0;
            m_last     <= 1'b0;
        end else begin
            n          <= n_nx;
            acc        <= acc_nx;
            flush_pend <= fp_nx;
            if (load) begin
                m_valid <= 1'b1;
                m_data  <= ld_data;
                m_keep  <= ld_keep;
                m_last  <= ld_last;
            end else if (m_ready) begin
                m_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rd_packer.sv
// Self-checking bench for fifo_rd_packer: FIFO model, scoreboard of expected words.
module tb_fifo_rd_packer;

    logic        rclk = 1'b0;
    logic        rrst;
    logic        rempty;
    logic [7:0]  rdata;
    logic        rinc;
    logic        flush;
    logic        m_valid;
    logic        m_ready;
    logic [31:0] m_data;
    logic [3:0]  m_keep;
    logic        m_last;

    typedef struct packed {
        logic [31:0] d;
        logic [3:0]  k;
        logic        l;
    } word_t;

    word_t sb[$];
    word_t mw;

    int unsigned errors = 0;
    int unsigned checks = 0;

    logic [7:0]  mem [0:255];
    int unsigned wr_ptr = 0;
    int unsigned rd_ptr = 0;

    fifo_rd_packer #(.DATASIZEL(8), .PACK(4)) dut (
        .rclk    (rclk),
        .rrst    (rrst),
        .rempty  (rempty),
        .rdata   (rdata),
        .rinc    (rinc),
        .flush   (flush),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_data  (m_data),
        .m_keep  (m_keep),
        .m_last  (m_last)
    );

    always #5 rclk = ~rclk;

    // Show-ahead FIFO model
    assign rempty = (rd_ptr == wr_ptr);
    assign rdata  = mem[rd_ptr[7:0]];

    always @(posedge rclk) begin
        if (rinc && !rempty) rd_ptr <= rd_ptr + 1;
    end

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic push(input logic [7:0] b);
        mem[wr_ptr[7:0]] = b;
        wr_ptr = wr_ptr + 1;
    endtask

    task automatic expect_word(input logic [31:0] d, input logic [3:0] k, input logic l);
        word_t w;
        w.d = d;
        w.k = k;
        w.l = l;
        sb.push_back(w);
    endtask

    task automatic tick(input int unsigned cnt);
        for (int unsigned i = 0; i < cnt; i++) begin
            @(posedge rclk);
            #1;
        end
    endtask

    // Compare every transferred word against the scoreboard head
    always @(negedge rclk) begin
        if (!rrst && m_valid && m_ready) begin
            check("sb_has_entry", 64'(sb.size() != 0), 64'd1);
            if (sb.size() != 0) begin
                mw = sb.pop_front();
                check("m_data", 64'(m_data), 64'(mw.d));
                check("m_keep", 64'(m_keep), 64'(mw.k));
                check("m_last", 64'(m_last), 64'(mw.l));
            end
        end
    end

    initial begin
        rrst    = 1'b1;
        flush   = 1'b0;
        m_ready = 1'b1;

        // Stream: preload 0x01..0x08 during reset
        for (int unsigned b = 1; b <= 8; b++) push(8'(b));
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        tick(2);
        check("rst_rinc", 64'(rinc), 64'd0);
        check("rst_m_valid", 64'(m_valid), 64'd0);
        check("rst_m_data", 64'(m_data), 64'd0);
        check("rst_m_keep", 64'(m_keep), 64'd0);
        check("rst_m_last", 64'(m_last), 64'd0);
        rrst = 1'b0;
        #0;
        check("rinc_after_rst", 64'(rinc), 64'd1);
        tick(3);
        check("stream_valid_pre", 64'(m_valid), 64'd0);
        tick(1);
        check("stream_valid_w0", 64'(m_valid), 64'd1);
        tick(3);
        check("stream_valid_gap", 64'(m_valid), 64'd0);
        tick(1);
        check("stream_valid_w1", 64'(m_valid), 64'd1);
        tick(3);

        // Flush partial
        push(8'hAA);
        push(8'hBB);
        expect_word(32'h0000BBAA, 4'h3, 1'b1);
        tick(2);
        check("fp_rinc_before", 64'(rinc), 64'd1);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("fp_rinc_pending", 64'(rinc), 64'd0);
        check("fp_valid_pending", 64'(m_valid), 64'd0);
        tick(1);
        check("fp_valid", 64'(m_valid), 64'd1);
        check("fp_rinc_after", 64'(rinc), 64'd1);
        tick(3);

        // Flush with empty accumulator
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("fe_rinc_pending", 64'(rinc), 64'd0);
        tick(1);
        check("fe_rinc_after", 64'(rinc), 64'd1);
        check("fe_pend_clear", 64'(dut.flush_pend), 64'd0);
        check("fe_no_valid", 64'(m_valid), 64'd0);
        tick(2);
        check("fe_still_no_valid", 64'(m_valid), 64'd0);

        // Backpressure: 12 bytes with m_ready low
        m_ready = 1'b0;
        for (int unsigned b = 1; b <= 12; b++) push(8'(b));
        expect_word(32'h04030201, 4'hF, 1'b0);
        expect_word(32'h08070605, 4'hF, 1'b0);
        expect_word(32'h0C0B0A09, 4'hF, 1'b0);
        tick(14);
        check("bp_valid", 64'(m_valid), 64'd1);
        check("bp_data", 64'(m_data), 64'h04030201);
        check("bp_rinc", 64'(rinc), 64'd0);
        check("bp_n_full", 64'(dut.n), 64'd4);
        check("bp_acc", 64'(dut.acc), 64'h08070605);
        check("bp_fifo_left", 64'(wr_ptr - rd_ptr), 64'd4);
        m_ready = 1'b1;
        tick(12);
        check("bp_fifo_drained", 64'(wr_ptr - rd_ptr), 64'd0);

        // Flush sampled on the edge that pops 0x33
        push(8'h11);
        push(8'h22);
        expect_word(32'h00332211, 4'h7, 1'b1);
        tick(2);
        push(8'h33);
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("fpe_n", 64'(dut.n), 64'd3);
        tick(1);
        check("fpe_valid", 64'(m_valid), 64'd1);
        tick(3);

        // Reset mid-operation: O holds a word, accumulator holds two bytes
        m_ready = 1'b0;
        for (int unsigned b = 8'h41; b <= 8'h44; b++) push(8'(b));
        push(8'h51);
        push(8'h52);
        tick(6);
        check("mr_valid_pre", 64'(m_valid), 64'd1);
        check("mr_n_pre", 64'(dut.n), 64'd2);
        rrst = 1'b1;
        tick(1);
        check("mr_m_valid", 64'(m_valid), 64'd0);
        check("mr_m_data", 64'(m_data), 64'd0);
        check("mr_m_keep", 64'(m_keep), 64'd0);
        check("mr_m_last", 64'(m_last), 64'd0);
        check("mr_rinc", 64'(rinc), 64'd0);
        check("mr_n", 64'(dut.n), 64'd0);
        rrst    = 1'b0;
        m_ready = 1'b1;
        for (int unsigned b = 8'h61; b <= 8'h64; b++) push(8'(b));
        expect_word(32'h64636261, 4'hF, 1'b0);
        tick(8);

        check("sb_drained", 64'(sb.size()), 64'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
